// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and a saturating stall counter.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  instrRs_D,
   input  logic [4:0]  instrRt_D,
   input  logic [4:0]  instrRd_D,
   input  logic [31:0] readData1_D,
   input  logic [31:0] readData2_D,
   input  logic [31:0] signImm_D,
   input  logic        regWrite_D,
   input  logic        memToReg_D,
   input  logic        memWrite_D,
   input  logic        aluSrc_D,
   input  logic        regDst_D,
   input  logic [2:0]  aluControl_D,
   input  logic        valid_D,
   input  logic        flush_E,
   input  logic        clrCnt,
   output logic [4:0]  instrRs_E,
   output logic [4:0]  instrRt_E,
   output logic [4:0]  writeReg_E,
   output logic [31:0] readData1_E,
   output logic [31:0] readData2_E,
   output logic [31:0] signImm_E,
   output logic        regWrite_E,
   output logic        memToReg_E,
   output logic        memWrite_E,
   output logic        aluSrc_E,
   output logic        valid_E,
   output logic [2:0]  aluControl_E,
   output logic        stall_F,
   output logic        stall_D,
   output logic [15:0] stallCount
);
   logic load_use;
   logic bubble;
   assign load_use = valid_E & memToReg_E & regWrite_E & (writeReg_E != 5'd0) & valid_D &
                     ((instrRs_D == writeReg_E) | (instrRt_D == writeReg_E));
   assign stall_D  = load_use & ~flush_E;
   assign stall_F  = stall_D;
   assign bubble   = flush_E | load_use | ~valid_D;
   // A bubble zeroes everything so the forwarding unit can never match on it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || bubble) begin
         instrRs_E    <= 5'd0;
         instrRt_E    <= 5'd0;
         writeReg_E   <= 5'd0;
         readData1_E  <= 32'd0;
         readData2_E  <= 32'd0;
         signImm_E    <= 32'd0;
         regWrite_E   <= 1'b0;
         memToReg_E   <= 1'b0;
         memWrite_E   <= 1'b0;
         aluSrc_E     <= 1'b0;
         valid_E      <= 1'b0;
         aluControl_E <= 3'd0;
      end else begin
         instrRs_E    <= instrRs_D;
         instrRt_E    <= instrRt_D;
         writeReg_E   <= regDst_D ? instrRd_D : instrRt_D;
         readData1_E  <= readData1_D;
         readData2_E  <= readData2_D;
         signImm_E    <= signImm_D;
         regWrite_E   <= regWrite_D;
         memToReg_E   <= memToReg_D;
         memWrite_E   <= memWrite_D;
         aluSrc_E     <= aluSrc_D;
         valid_E      <= 1'b1;
         aluControl_E <= aluControl_D;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stallCount <= 16'd0;
      else
         stallCount <= clrCnt ? 16'd0 :
                       (stall_D && stallCount != 16'hFFFF) ? stallCount + 16'd1 : stallCount;
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, random stimulus against a behavioural model, and counter saturation.
module tb_id_ex_stage;
   typedef struct packed {
      logic [4:0]  rs, rt, rd;
      logic [31:0] r1, r2, imm;
      logic        rw, m2r, mw, asrc, rdst;
      logic [2:0]  alu;
      logic        valid;
   } d_t;
   typedef struct packed {
      logic [4:0]  rs, rt, wr;
      logic [31:0] r1, r2, imm;
      logic        rw, m2r, mw, asrc;
      logic [2:0]  alu;
      logic        valid;
   } e_t;
   typedef struct {
      d_t         d;
      logic       flush, clr, stall;
      logic [4:0] rs, wr;
      logic       rw, valid;
      logic [15:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   logic run = 1'b0;
   logic rst_n, flush, clr;
   d_t d;
   logic [4:0] instrRs_E, instrRt_E, writeReg_E;
   logic [31:0] readData1_E, readData2_E, signImm_E;
   logic regWrite_E, memToReg_E, memWrite_E, aluSrc_E, valid_E, stall_F, stall_D;
   logic [2:0] aluControl_E;
   logic [15:0] stallCount;
   e_t got, me;
   logic [15:0] cnt;
   int n_chk = 0;
   int n_fail = 0;
   vec_t tv[19];
   logic st;

   assign got = {instrRs_E, instrRt_E, writeReg_E, readData1_E, readData2_E, signImm_E,
                 regWrite_E, memToReg_E, memWrite_E, aluSrc_E, aluControl_E, valid_E};

   always #5 clk = run ? ~clk : 1'b0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .instrRs_D(d.rs), .instrRt_D(d.rt), .instrRd_D(d.rd),
      .readData1_D(d.r1), .readData2_D(d.r2), .signImm_D(d.imm),
      .regWrite_D(d.rw), .memToReg_D(d.m2r), .memWrite_D(d.mw), .aluSrc_D(d.asrc),
      .regDst_D(d.rdst), .aluControl_D(d.alu), .valid_D(d.valid),
      .flush_E(flush), .clrCnt(clr),
      .instrRs_E(instrRs_E), .instrRt_E(instrRt_E), .writeReg_E(writeReg_E),
      .readData1_E(readData1_E), .readData2_E(readData2_E), .signImm_E(signImm_E),
      .regWrite_E(regWrite_E), .memToReg_E(memToReg_E), .memWrite_E(memWrite_E),
      .aluSrc_E(aluSrc_E), .valid_E(valid_E), .aluControl_E(aluControl_E),
      .stall_F(stall_F), .stall_D(stall_D), .stallCount(stallCount)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // E holds a live load whose nonzero destination is a source of the instruction in D
   function automatic logic must_wait(input e_t e, input d_t x);
      return e.valid && e.m2r && e.rw && e.wr != 5'd0 && x.valid && (x.rs == e.wr || x.rt == e.wr);
   endfunction

   function automatic d_t mk(input logic [4:0] rs, rt, rd, input logic rw, m2r, rdst, v);
      d_t x;
      x = '0;
      x.rs = rs; x.rt = rt; x.rd = rd; x.rw = rw; x.m2r = m2r; x.rdst = rdst; x.valid = v;
      x.r1 = 32'hA000_0000 | 32'(rs);
      x.r2 = 32'hB000_0000 | 32'(rt);
      x.imm = 32'hFFFF_FF00 | 32'(rd);
      x.alu = 3'd2;
      return x;
   endfunction

   function automatic d_t rnd_d();
      d_t x;
      x.rs = 5'($urandom_range(0, 3));
      x.rt = 5'($urandom_range(0, 3));
      x.rd = 5'($urandom_range(0, 3));
      x.r1 = $urandom; x.r2 = $urandom; x.imm = $urandom;
      x.rw = 1'($urandom); x.m2r = 1'($urandom); x.mw = 1'($urandom);
      x.asrc = 1'($urandom); x.rdst = 1'($urandom);
      x.alu = 3'($urandom);
      x.valid = ($urandom_range(0, 9) != 0);
      return x;
   endfunction

   task automatic tick(output logic stall_seen);
      logic es;
      #1;
      es = must_wait(me, d) && !flush;
      stall_seen = stall_D;
      chk("stall_D", 128'(stall_D), 128'(es));
      chk("stall_F", 128'(stall_F), 128'(es));
      @(posedge clk);
      if (flush || must_wait(me, d) || !d.valid)
         me = '0;
      else
         me = '{rs: d.rs, rt: d.rt, wr: (d.rdst ? d.rd : d.rt), r1: d.r1, r2: d.r2, imm: d.imm,
                rw: d.rw, m2r: d.m2r, mw: d.mw, asrc: d.asrc, alu: d.alu, valid: 1'b1};
      if (clr) cnt = 16'd0;
      else if (es && cnt != 16'hFFFF) cnt = cnt + 16'd1;
      #1;
      chk("e_stage", 128'(got), 128'(me));
      chk("stallCount", 128'(stallCount), 128'(cnt));
   endtask

   initial begin
      rst_n = 1'b1; flush = 1'b0; clr = 1'b0; d = '0;
      me = '0; cnt = 16'd0;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = rnd_d();
         d.rs = 5'd1; d.rt = 5'd1;
         #2;
         chk("reset_e", 128'(got), 128'(0));
         chk("reset_stall", 128'({stall_F, stall_D}), 128'(0));
         chk("reset_cnt", 128'(stallCount), 128'(0));
      end
      d = mk(5'd9, 5'd11, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b1;
      run = 1'b1;
      tick(st);
      chk("first_rs", 128'(instrRs_E), 128'(9));
      chk("first_rt", 128'(instrRt_E), 128'(11));

      tv[0]  = '{mk(5'd9, 5'd11, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 5'd9, 5'd5, 1'b1, 1'b1, 16'd0};
      tv[1]  = '{mk(5'd9, 5'd11, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd9, 5'd11, 1'b1, 1'b1, 16'd0};
      tv[2]  = '{mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd2, 5'd8, 1'b1, 1'b1, 16'd0};
      tv[3]  = '{mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 16'd1};
      tv[4]  = '{mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 5'd8, 5'd10, 1'b1, 1'b1, 16'd1};
      tv[5]  = '{mk(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 1'b1, 1'b1, 16'd1};
      tv[6]  = '{mk(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 1'b1, 1'b1, 16'd1};
      tv[7]  = '{mk(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd1, 5'd8, 1'b1, 1'b1, 16'd1};
      tv[8]  = '{mk(5'd8, 5'd8, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 5'd8, 5'd6, 1'b1, 1'b1, 16'd1};
      tv[9]  = '{mk(5'd3, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd3, 5'd8, 1'b1, 1'b1, 16'd1};
      tv[10] = '{mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'd1};
      tv[11] = '{mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 5'd8, 5'd10, 1'b1, 1'b1, 16'd1};
      tv[12] = '{mk(5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'd1};
      tv[13] = '{mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd2, 5'd8, 1'b1, 1'b1, 16'd1};
      tv[14] = '{mk(5'd8, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 16'd2};
      tv[15] = '{mk(5'd8, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 1'b1, 1'b1, 16'd2};
      tv[16] = '{mk(5'd1, 5'd9, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 16'd3};
      tv[17] = '{mk(5'd1, 5'd9, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, 5'd1, 5'd12, 1'b1, 1'b1, 16'd3};
      tv[18] = '{mk(5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0, 5'd4, 5'd6, 1'b1, 1'b1, 16'd0};
      foreach (tv[i]) begin
         d = tv[i].d; flush = tv[i].flush; clr = tv[i].clr;
         tick(st);
         chk($sformatf("vec%0d_stall", i), 128'(st), 128'(tv[i].stall));
         chk($sformatf("vec%0d_rs", i), 128'(instrRs_E), 128'(tv[i].rs));
         chk($sformatf("vec%0d_wr", i), 128'(writeReg_E), 128'(tv[i].wr));
         chk($sformatf("vec%0d_ctl", i), 128'({regWrite_E, valid_E}), 128'({tv[i].rw, tv[i].valid}));
         chk($sformatf("vec%0d_cnt", i), 128'(stallCount), 128'(tv[i].cnt));
      end
      flush = 1'b0; clr = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         d = rnd_d();
         flush = ($urandom_range(0, 9) == 0);
         clr = ($urandom_range(0, 19) == 0);
         tick(st);
      end
      flush = 1'b0; clr = 1'b0;

      // asynchronous reset between edges, then a normal capture on the first edge
      rst_n = 1'b0;
      me = '0; cnt = 16'd0;
      #1;
      chk("midreset_e", 128'(got), 128'(0));
      chk("midreset_cnt", 128'(stallCount), 128'(0));
      rst_n = 1'b1;
      d = mk(5'd9, 5'd11, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(st);
      chk("midreset_capture", 128'({instrRs_E, instrRt_E, valid_E}), 128'({5'd9, 5'd11, 1'b1}));

      while (cnt != 16'hFFFF) begin
         d = mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
         tick(st);
         d = mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
         tick(st);
      end
      chk("sat_reached", 128'(stallCount), 128'(16'hFFFF));
      for (int i = 0; i < 2; i++) begin
         d = mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
         tick(st);
         d = mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
         tick(st);
         chk("sat_stall", 128'(st), 128'(1));
         chk("sat_hold", 128'(stallCount), 128'(16'hFFFF));
      end
      d = mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(st);
      d = mk(5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
      clr = 1'b1;
      tick(st);
      chk("clr_with_stall", 128'({st, stallCount}), 128'({1'b1, 16'd0}));
      clr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
